// File: rtl/board_pkg.sv
// Shared board definitions for the multi-player token controller: state
// encoding, default geometry/timing and the lane-aware tile-to-pixel helper.
package board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MOVE   = 3'd1,
        ST_JUMP   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int D_NUM_PLAYERS   = 2;
    localparam int D_NUM_TILES     = 10;
    localparam int D_TILE_SIZE     = 48;
    localparam int D_PLAYER_OFFSET = 16;
    localparam int D_LANE_DX       = 4;
    localparam int D_BASE_Y        = 124;
    localparam int D_MOVE_FRAMES   = 24;
    localparam int D_JUMP_FRAMES   = 16;
    localparam int D_JUMP_STEP     = 4;
    localparam int D_MAX_STEPS     = 6;

    // Resting x of player p on tile t; each player gets its own lane so tokens never overlap.
    function automatic logic [9:0] base_x(input logic [3:0] tile, input logic [1:0] p,
                                          input int tile_size, input int offset,
                                          input int lane_dx);
        return 10'(int'(tile) * tile_size + offset + int'(p) * lane_dx);
    endfunction

endpackage

// File: rtl/jump_profile.sv
// Triangular jump height: rises JUMP_STEP px per frame to a peak at the
// half-way frame, then falls back symmetrically to zero.
module jump_profile
    import board_pkg::*;
#(
    parameter int JUMP_FRAMES = D_JUMP_FRAMES,
    parameter int JUMP_STEP   = D_JUMP_STEP
) (
    input  logic [7:0] i_cnt,
    output logic [9:0] o_off
);

    // Rising half uses the counter directly, falling half mirrors it.
    always_comb begin
        o_off = 10'd0;
        if (int'(i_cnt) < (JUMP_FRAMES / 2)) begin
            o_off = 10'(JUMP_STEP * int'(i_cnt));
        end else begin
            o_off = 10'(JUMP_STEP * (JUMP_FRAMES - int'(i_cnt)));
        end
    end

endmodule

// File: rtl/multi_player_ctrl.sv
// Turn-based board token controller: accepts dice moves for the active player,
// animates slide + hop per tile on frame ticks, and detects the winner.
module multi_player_ctrl
    import board_pkg::*;
#(
    parameter int NUM_PLAYERS   = D_NUM_PLAYERS,
    parameter int NUM_TILES     = D_NUM_TILES,
    parameter int TILE_SIZE     = D_TILE_SIZE,
    parameter int PLAYER_OFFSET = D_PLAYER_OFFSET,
    parameter int LANE_DX       = D_LANE_DX,
    parameter int BASE_Y        = D_BASE_Y,
    parameter int MOVE_FRAMES   = D_MOVE_FRAMES,
    parameter int JUMP_FRAMES   = D_JUMP_FRAMES,
    parameter int JUMP_STEP     = D_JUMP_STEP,
    parameter int MAX_STEPS     = D_MAX_STEPS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      move_valid,
    input  logic [2:0]                move_steps,
    output logic                      move_ready,
    input  logic                      restart,
    output logic [NUM_PLAYERS*10-1:0] player_x,
    output logic [NUM_PLAYERS*10-1:0] player_y,
    output logic [NUM_PLAYERS*4-1:0]  player_tile,
    output logic [1:0]                active_player,
    output logic                      busy,
    output logic                      turn_done,
    output logic                      game_over,
    output logic [1:0]                winner
);

    localparam logic [7:0] MOVE_LAST   = 8'(MOVE_FRAMES - 1);
    localparam logic [7:0] JUMP_LAST   = 8'(JUMP_FRAMES - 1);
    localparam logic [3:0] TILE_LAST   = 4'(NUM_TILES - 1);
    localparam logic [2:0] STEPS_MAX   = 3'(MAX_STEPS);
    localparam logic [1:0] PLAYER_LAST = 2'(NUM_PLAYERS - 1);

    state_t                   r_state;
    logic [NUM_PLAYERS*4-1:0] r_tile;
    logic [1:0]               r_active;
    logic [7:0]               r_cnt;
    logic [2:0]               r_steps;
    logic                     r_turn_done;
    logic                     r_game_over;
    logic [1:0]               r_winner;

    logic [2:0]               w_steps_clamp;
    logic [3:0]               w_cur_tile;
    logic [3:0]               w_tile_inc;
    logic [1:0]               w_next_player;
    logic [9:0]               w_frac;
    logic [9:0]               w_off;

    assign w_steps_clamp = (move_steps > STEPS_MAX) ? STEPS_MAX : move_steps;
    assign w_cur_tile    = r_tile[{r_active, 2'b00} +: 4];
    assign w_tile_inc    = (w_cur_tile < TILE_LAST) ? (w_cur_tile + 4'd1) : TILE_LAST;
    assign w_next_player = (r_active == PLAYER_LAST) ? 2'd0 : (r_active + 2'd1);
    assign w_frac        = 10'((TILE_SIZE * int'(r_cnt)) / MOVE_FRAMES);

    jump_profile #(
        .JUMP_FRAMES (JUMP_FRAMES),
        .JUMP_STEP   (JUMP_STEP)
    ) u_jump_profile (
        .i_cnt (r_cnt),
        .o_off (w_off)
    );

    // Turn sequencer; restart outranks any request arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tile      <= '0;
            r_active    <= 2'd0;
            r_cnt       <= 8'd0;
            r_steps     <= 3'd0;
            r_turn_done <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'd0;
        end else if (restart) begin
            r_state     <= ST_IDLE;
            r_tile      <= '0;
            r_active    <= 2'd0;
            r_cnt       <= 8'd0;
            r_steps     <= 3'd0;
            r_turn_done <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'd0;
        end else begin
            r_turn_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (move_valid) begin
                        r_cnt   <= 8'd0;
                        r_steps <= w_steps_clamp;
                        if (w_steps_clamp == 3'd0) begin
                            r_state     <= ST_NEXT;
                            r_turn_done <= 1'b1;
                        end else begin
                            r_state <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (frame_tick) begin
                        if (r_cnt == MOVE_LAST) begin
                            r_cnt                        <= 8'd0;
                            r_tile[{r_active, 2'b00} +: 4] <= w_tile_inc;
                            r_steps                      <= r_steps - 3'd1;
                            r_state                      <= ST_JUMP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_JUMP: begin
                    if (frame_tick) begin
                        if (r_cnt == JUMP_LAST) begin
                            r_cnt <= 8'd0;
                            // Landing on the last tile ends the game and drops any leftover steps.
                            if (w_cur_tile == TILE_LAST) begin
                                r_state     <= ST_FINISH;
                                r_steps     <= 3'd0;
                                r_game_over <= 1'b1;
                                r_winner    <= r_active;
                                r_turn_done <= 1'b1;
                            end else if (r_steps != 3'd0) begin
                                r_state <= ST_MOVE;
                            end else begin
                                r_state     <= ST_NEXT;
                                r_turn_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    r_active <= w_next_player;
                    r_state  <= ST_IDLE;
                end
                ST_FINISH: begin
                    r_state <= ST_FINISH;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel decode: only the active token slides (MOVE) or hops (JUMP).
    always_comb begin
        player_x = '0;
        player_y = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            player_x[p*10 +: 10] = base_x(r_tile[p*4 +: 4], 2'(p), TILE_SIZE, PLAYER_OFFSET, LANE_DX)
                                 + (((p == int'(r_active)) && (r_state == ST_MOVE)) ? w_frac : 10'd0);
            player_y[p*10 +: 10] = 10'(BASE_Y)
                                 - (((p == int'(r_active)) && (r_state == ST_JUMP)) ? w_off : 10'd0);
        end
    end

    assign move_ready    = (r_state == ST_IDLE);
    assign busy          = (r_state == ST_MOVE) || (r_state == ST_JUMP) || (r_state == ST_NEXT);
    assign player_tile   = r_tile;
    assign active_player = r_active;
    assign turn_done     = r_turn_done;
    assign game_over     = r_game_over;
    assign winner        = r_winner;

endmodule

// File: tb/tb_multi_player_ctrl.sv
// Directed bench for multi_player_ctrl at default parameters (2 players, 10 tiles).
module tb_multi_player_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        move_valid;
    logic [2:0]  move_steps;
    logic        move_ready;
    logic        restart;
    logic [19:0] player_x;
    logic [19:0] player_y;
    logic [7:0]  player_tile;
    logic [1:0]  active_player;
    logic        busy;
    logic        turn_done;
    logic        game_over;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_fail   = 0;

    multi_player_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .move_valid    (move_valid),
        .move_steps    (move_steps),
        .move_ready    (move_ready),
        .restart       (restart),
        .player_x      (player_x),
        .player_y      (player_y),
        .player_tile   (player_tile),
        .active_player (active_player),
        .busy          (busy),
        .turn_done     (turn_done),
        .game_over     (game_over),
        .winner        (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_restart(input logic with_valid);
        restart    = 1'b1;
        move_valid = with_valid;
        move_steps = 3'd2;
        step_cycle();
        restart    = 1'b0;
        move_valid = 1'b0;
    endtask

    // Issue one move with a tick every cycle; returns cycles from MOVE entry to turn_done.
    task automatic do_move(input logic [2:0] s, input int limit, output int n);
        frame_tick = 1'b1;
        move_valid = 1'b1;
        move_steps = s;
        step_cycle();
        move_valid = 1'b0;
        n = 0;
        while (!turn_done && n < limit) begin
            step_cycle();
            n++;
        end
        n_checks++;
        if (n >= limit) begin
            n_fail++;
            $display("FAIL move_timeout: no turn_done after %0d cycles (steps %0d)", n, s);
        end
        step_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b0; move_valid = 1'b0; move_steps = 3'd0; restart = 1'b0;
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        step_cycle();
        n_checks++; if (player_x !== {10'd20, 10'd16}) begin n_fail++; $display("FAIL reset_x: got %h want %h", player_x, {10'd20, 10'd16}); end
        n_checks++; if (player_y !== {10'd124, 10'd124}) begin n_fail++; $display("FAIL reset_y: got %h want %h", player_y, {10'd124, 10'd124}); end
        n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", move_ready); end
        n_checks++; if (game_over !== 1'b0 || busy !== 1'b0 || turn_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags: go %b busy %b td %b want 0", game_over, busy, turn_done); end
        n_checks++; if (player_tile !== 8'h00 || active_player !== 2'd0) begin n_fail++; $display("FAIL reset_tile: tile %h act %0d want 0/0", player_tile, active_player); end
    endtask

    task automatic test_single_step();
        int off;
        frame_tick = 1'b1;
        move_valid = 1'b1;
        move_steps = 3'd1;
        step_cycle();
        move_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || move_ready !== 1'b0) begin n_fail++; $display("FAIL move_busy: busy %b ready %b want 1/0", busy, move_ready); end
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step_cycle();
            n_checks++;
            if (player_x[9:0] !== 10'(16 + 2 * i)) begin n_fail++; $display("FAIL slide_x[%0d]: got %0d want %0d", i, player_x[9:0], 16 + 2 * i); end
        end
        step_cycle();
        n_checks++; if (player_tile[3:0] !== 4'd1 || player_x[9:0] !== 10'd64) begin n_fail++; $display("FAIL jump_start: tile %0d x %0d want 1/64", player_tile[3:0], player_x[9:0]); end
        for (int c = 1; c < 16; c++) begin
            step_cycle();
            off = (c < 8) ? 4 * c : 4 * (16 - c);
            n_checks++;
            if (player_y[9:0] !== 10'(124 - off)) begin n_fail++; $display("FAIL jump_y[%0d]: got %0d want %0d", c, player_y[9:0], 124 - off); end
        end
        n_checks++; if (player_y[19:10] !== 10'd124 || player_x[19:10] !== 10'd20) begin n_fail++; $display("FAIL idle_token: x %0d y %0d want 20/124", player_x[19:10], player_y[19:10]); end
        step_cycle();
        n_checks++; if (turn_done !== 1'b1 || active_player !== 2'd0) begin n_fail++; $display("FAIL next_pulse: td %b act %0d want 1/0", turn_done, active_player); end
        step_cycle();
        n_checks++; if (turn_done !== 1'b0 || active_player !== 2'd1 || move_ready !== 1'b1) begin n_fail++; $display("FAIL next_done: td %b act %0d ready %b want 0/1/1", turn_done, active_player, move_ready); end
    endtask

    task automatic test_clamp();
        int n;
        do_restart(1'b1);
        n_checks++; if (move_ready !== 1'b1 || busy !== 1'b0 || player_tile !== 8'h00 || active_player !== 2'd0) begin n_fail++; $display("FAIL restart_wins: ready %b busy %b tile %h act %0d want 1/0/00/0", move_ready, busy, player_tile, active_player); end
        do_move(3'd7, 400, n);
        n_checks++; if (n !== 240) begin n_fail++; $display("FAIL clamp_cycles: got %0d want 240", n); end
        n_checks++; if (player_tile[3:0] !== 4'd6 || active_player !== 2'd1) begin n_fail++; $display("FAIL clamp_tile: tile %0d act %0d want 6/1", player_tile[3:0], active_player); end
    endtask

    task automatic test_finish();
        int n;
        do_restart(1'b0);
        do_move(3'd0, 10, n);
        n_checks++; if (n !== 0 || active_player !== 2'd1 || player_tile !== 8'h00) begin n_fail++; $display("FAIL zero_step: n %0d act %0d tile %h want 0/1/00", n, active_player, player_tile); end
        do_move(3'd6, 400, n);
        do_move(3'd0, 10, n);
        do_move(3'd2, 400, n);
        n_checks++; if (player_tile !== 8'h80 || active_player !== 2'd0) begin n_fail++; $display("FAIL setup_tile8: tile %h act %0d want 80/0", player_tile, active_player); end
        do_move(3'd0, 10, n);
        do_move(3'd3, 400, n);
        n_checks++; if (n !== 40) begin n_fail++; $display("FAIL finish_cycles: got %0d want 40", n); end
        n_checks++; if (player_tile[7:4] !== 4'd9 || game_over !== 1'b1 || winner !== 2'd1) begin n_fail++; $display("FAIL finish_state: tile %0d go %b win %0d want 9/1/1", player_tile[7:4], game_over, winner); end
        n_checks++; if (move_ready !== 1'b0 || busy !== 1'b0 || turn_done !== 1'b0) begin n_fail++; $display("FAIL finish_flags: ready %b busy %b td %b want 0/0/0", move_ready, busy, turn_done); end
        move_valid = 1'b1; move_steps = 3'd2;
        step_cycle();
        step_cycle();
        move_valid = 1'b0;
        n_checks++; if (player_tile[7:4] !== 4'd9 || game_over !== 1'b1) begin n_fail++; $display("FAIL finish_hold: tile %0d go %b want 9/1", player_tile[7:4], game_over); end
        do_restart(1'b0);
        n_checks++; if (player_tile !== 8'h00 || active_player !== 2'd0 || game_over !== 1'b0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL restart_clear: tile %h act %0d go %b ready %b want 00/0/0/1", player_tile, active_player, game_over, move_ready); end
    endtask

    task automatic test_slow_tick();
        int k;
        do_restart(1'b0);
        frame_tick = 1'b0;
        move_valid = 1'b1;
        move_steps = 3'd1;
        step_cycle();
        move_valid = 1'b0;
        for (k = 0; k < 8; k++) begin
            frame_tick = ((k % 4) == 3);
            move_valid = (k == 4) || (k == 5);
            move_steps = 3'd5;
            step_cycle();
            if (k == 4) begin
                n_checks++; if (player_x[9:0] !== 10'd18) begin n_fail++; $display("FAIL slow_x1: got %0d want 18", player_x[9:0]); end
            end
        end
        move_valid = 1'b0;
        n_checks++; if (player_x[9:0] !== 10'd20) begin n_fail++; $display("FAIL slow_x2: got %0d want 20", player_x[9:0]); end
        while (!turn_done && k < 400) begin
            frame_tick = ((k % 4) == 3);
            step_cycle();
            k++;
        end
        n_checks++; if (k !== 160) begin n_fail++; $display("FAIL slow_cycles: got %0d want 160", k); end
        frame_tick = 1'b0;
        step_cycle();
        n_checks++; if (player_tile[3:0] !== 4'd1 || active_player !== 2'd1) begin n_fail++; $display("FAIL ignored_valid: tile %0d act %0d want 1/1", player_tile[3:0], active_player); end
    endtask

    task automatic test_reset_mid_jump();
        int n;
        do_restart(1'b0);
        frame_tick = 1'b1;
        move_valid = 1'b1;
        move_steps = 3'd3;
        step_cycle();
        move_valid = 1'b0;
        repeat (109) step_cycle();
        n_checks++; if (player_tile[3:0] !== 4'd3 || player_y[9:0] !== 10'd104 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_jump: tile %0d y %0d busy %b want 3/104/1", player_tile[3:0], player_y[9:0], busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (player_x !== {10'd20, 10'd16} || player_y !== {10'd124, 10'd124}) begin n_fail++; $display("FAIL async_xy: x %h y %h want %h/%h", player_x, player_y, {10'd20, 10'd16}, {10'd124, 10'd124}); end
        n_checks++; if (player_tile !== 8'h00 || busy !== 1'b0 || move_ready !== 1'b1 || active_player !== 2'd0 || turn_done !== 1'b0) begin n_fail++; $display("FAIL async_state: tile %h busy %b ready %b act %0d td %b", player_tile, busy, move_ready, active_player, turn_done); end
        @(negedge clk);
        rst_n = 1'b1;
        step_cycle();
        do_move(3'd1, 200, n);
        n_checks++; if (n !== 40 || player_tile[3:0] !== 4'd1) begin n_fail++; $display("FAIL post_reset_move: n %0d tile %0d want 40/1", n, player_tile[3:0]); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_clamp();
        test_finish();
        test_slow_tick();
        test_reset_mid_jump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
